cic_comp_fir_decim: RTL

//   CIC droop-compensation FIR for the decimator output. Consumes the 3-stage CIC

---
 rtl/cic_comp_fir_decim.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/cic_comp_fir_decim.sv
// rtl/cic_comp_fir_decim.sv - time-serial CIC droop-compensation FIR with optional decimation by 2
module cic_comp_fir_decim #(
    parameter int DATA_WIDTH   = 15,
    parameter int COEF_WIDTH   = 16,
    parameter int COEF_FRAC    = 14,
    parameter int NTAPS        = 16,
    parameter int OUTPUT_WIDTH = 16,
    parameter int DECIM        = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    input  logic [DATA_WIDTH-1:0]    in_data,
    input  logic                     coef_we,
    input  logic [$clog2(NTAPS)-1:0] coef_addr,
    input  logic [COEF_WIDTH-1:0]    coef_data,
    input  logic                     overrun_clr,
    output logic                     out_valid,
    output logic [OUTPUT_WIDTH-1:0]  out_data,
    output logic                     busy,
    output logic                     overrun
);

    localparam int AB = $clog2(NTAPS);
    localparam int PW = DATA_WIDTH + COEF_WIDTH;
    localparam int AW = PW + AB;

    localparam logic signed [COEF_WIDTH-1:0] UNITY = COEF_WIDTH'(2 ** COEF_FRAC);
    localparam logic signed [AW:0] HALF    = (AW + 1)'(2 ** (COEF_FRAC - 1));
    localparam logic signed [AW:0] SAT_MAX = {{(AW + 2 - OUTPUT_WIDTH){1'b0}}, {(OUTPUT_WIDTH - 1){1'b1}}};
    localparam logic signed [AW:0] SAT_MIN = {{(AW + 2 - OUTPUT_WIDTH){1'b1}}, {(OUTPUT_WIDTH - 1){1'b0}}};
    localparam logic [AB-1:0] LAST = AB'(NTAPS - 1);

    typedef enum logic [1:0] {IDLE, MAC, ROUND} state_t;

    state_t                       state;
    logic signed [COEF_WIDTH-1:0] coef  [NTAPS];
    logic signed [DATA_WIDTH-1:0] dline [NTAPS];
    logic [AB-1:0]                wptr;
    logic [AB-1:0]                rptr;
    logic [AB-1:0]                tap;
    logic                         phase;
    logic signed [AW-1:0]         acc;
    logic signed [PW-1:0]         prod;
    logic signed [AW:0]           rsum;
    logic signed [AW:0]           rshift;
    logic signed [AW:0]           sat_val;
    logic [AB-1:0]                wptr_next;
    logic [AB-1:0]                rptr_prev;
    logic                         phase_wrap;
    logic                         accept;

    assign busy       = (state != IDLE);
    assign accept     = in_valid && (state == IDLE);
    assign phase_wrap = (DECIM == 1) ? 1'b1 : phase;
    assign wptr_next  = (wptr == LAST) ? '0 : wptr + 1'b1;
    assign rptr_prev  = (rptr == '0) ? LAST : rptr - 1'b1;
    assign prod       = coef[tap] * dline[rptr];

    // Round half toward +inf, arithmetic shift back to integer scale, then clamp to the output range
    always_comb begin
        rsum    = $signed({acc[AW-1], acc}) + HALF;
        rshift  = rsum >>> COEF_FRAC;
        sat_val = rshift;
        if (rshift > SAT_MAX) begin
            sat_val = SAT_MAX;
        end else if (rshift < SAT_MIN) begin
            sat_val = SAT_MIN;
        end
    end

    // Coefficient bank: writable only while idle so an in-flight MAC never sees a half-updated set
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NTAPS; i++) begin
                coef[i] <= (i == 0) ? UNITY : '0;
            end
        end else if (coef_we && (state == IDLE)) begin
            coef[coef_addr] <= coef_data;
        end
    end

    // Circular delay line: newest accepted sample lands at wptr
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NTAPS; i++) begin
                dline[i] <= '0;
            end
        end else if (accept) begin
            dline[wptr] <= in_data;
        end
    end

    // Sticky overrun: a drop in the same cycle as a clear keeps the flag set
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun <= 1'b0;
        end else if (in_valid && (state != IDLE)) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

    // Control FSM: accept/decimate in IDLE, one MAC per clock walking back from the newest sample, then round
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            wptr      <= '0;
            rptr      <= '0;
            tap       <= '0;
            phase     <= 1'b0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        wptr  <= wptr_next;
                        phase <= phase_wrap ? 1'b0 : 1'b1;
                        if (phase_wrap) begin
                            state <= MAC;
                            acc   <= '0;
                            tap   <= '0;
                            rptr  <= wptr;
                        end
                    end
                end
                MAC: begin
                    acc  <= acc + $signed({{AB{prod[PW-1]}}, prod});
                    tap  <= tap + 1'b1;
                    rptr <= rptr_prev;
                    if (tap == LAST) begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    out_data  <= sat_val[OUTPUT_WIDTH-1:0];
                    out_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
